// File: rtl/uart_bus_master_pkg.sv
// Shared constants and state encodings for the UART-to-bus bridge.
package uart_bus_master_pkg;
  localparam logic [7:0] CMD_WRITE  = 8'h57;
  localparam logic [7:0] CMD_READ   = 8'h52;
  localparam logic [7:0] RSP_OK     = 8'h4B;
  localparam logic [7:0] RSP_ERR    = 8'h45;
  localparam logic [7:0] RSP_BADCMD = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_DATA, ST_CHECK, ST_BUS, ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_GAP, TX_WAIT
  } tx_state_t;
endpackage

// File: rtl/uart_bus_master_if.sv
// Native memory bus, requester side is the master modport.
interface uart_bus_master_if;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;

  modport master (output m_valid, m_addr, m_wdata, m_wstrb, input m_ready, m_rdata);
  modport slave  (input m_valid, m_addr, m_wdata, m_wstrb, output m_ready, m_rdata);
endinterface

// File: rtl/uart_bm_resp_tx.sv
// Response sequencer: streams 1..4 bytes of a word LSB first through the
// transmitter start/busy handshake, then pulses done.
module uart_bm_resp_tx
  import uart_bus_master_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] word,
  input  logic [2:0]  len,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        done
);
  tx_state_t   st;
  logic [23:0] sh;
  logic [1:0]  left;

  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= TX_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      done     <= 1'b0;
      sh       <= '0;
      left     <= '0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (st)
        TX_IDLE: if (start) begin
          tx_start <= 1'b1;
          tx_data  <= word[7:0];
          sh       <= word[31:8];
          left     <= 2'(len - 3'd1);
          st       <= TX_START;
        end
        TX_START: st <= TX_GAP;
        // busy only rises the cycle after tx_start, so it is not trusted here
        TX_GAP:   st <= TX_WAIT;
        TX_WAIT: if (!tx_busy) begin
          if (left == 2'd0) begin
            done <= 1'b1;
            st   <= TX_IDLE;
          end else begin
            tx_start <= 1'b1;
            tx_data  <= sh[7:0];
            sh       <= {8'h00, sh[23:8]};
            left     <= left - 2'd1;
            st       <= TX_START;
          end
        end
        default: st <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/uart_bus_master.sv
// UART command-frame parser acting as initiator on the native memory bus.
// 'W' A0..A3 D0..D3 writes, 'R' A0..A3 reads; replies go out via uart_bm_resp_tx.
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 1000000,
  parameter int unsigned BUS_TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  uart_bus_master_if.master  bus,
  output logic               busy
);
  state_t      state;
  logic [7:0]  cmd;
  logic [31:0] addr, wdata, tmo;
  logic [1:0]  idx;
  logic        rsp_go, rsp_done;
  logic [31:0] rsp_word;
  logic [2:0]  rsp_len;

  assign busy = (state != ST_IDLE);

  // Response launch is combinational so the sequencer registers tx_start
  // on the same edge that samples the deciding byte or m_ready.
  always_comb begin
    rsp_go   = 1'b0;
    rsp_word = {24'h0, RSP_ERR};
    rsp_len  = 3'd1;
    case (state)
      ST_IDLE: if (rx_valid && rx_data != CMD_WRITE && rx_data != CMD_READ) begin
        rsp_go   = 1'b1;
        rsp_word = {24'h0, RSP_BADCMD};
      end
      ST_CHECK: rsp_go = (addr[1:0] != 2'b00);
      ST_BUS: if (bus.m_ready) begin
        rsp_go = 1'b1;
        if (cmd == CMD_READ) begin
          rsp_word = bus.m_rdata;
          rsp_len  = 3'd4;
        end else begin
          rsp_word = {24'h0, RSP_OK};
        end
      end else if (tmo == BUS_TIMEOUT - 1) begin
        rsp_go = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cmd         <= '0;
      addr        <= '0;
      wdata       <= '0;
      tmo         <= '0;
      idx         <= '0;
      bus.m_valid <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
      bus.m_wstrb <= '0;
    end else begin
      case (state)
        ST_IDLE: if (rx_valid) begin
          cmd   <= rx_data;
          idx   <= '0;
          tmo   <= '0;
          state <= rsp_go ? ST_RESP : ST_ADDR;
        end
        ST_ADDR, ST_DATA: begin
          // an arriving byte always beats the timeout on the same cycle
          if (rx_valid) begin
            tmo <= '0;
            idx <= idx + 2'd1;
            if (state == ST_ADDR) addr  <= {rx_data, addr[31:8]};
            else                  wdata <= {rx_data, wdata[31:8]};
            if (idx == 2'd3)
              state <= (state == ST_ADDR && cmd == CMD_WRITE) ? ST_DATA : ST_CHECK;
          end else if (tmo == BYTE_TIMEOUT - 1) begin
            state <= ST_IDLE;
          end else begin
            tmo <= tmo + 32'd1;
          end
        end
        ST_CHECK: begin
          tmo <= '0;
          if (rsp_go) begin
            state <= ST_RESP;
          end else begin
            state       <= ST_BUS;
            bus.m_valid <= 1'b1;
            bus.m_addr  <= addr;
            bus.m_wdata <= (cmd == CMD_WRITE) ? wdata : 32'h0;
            bus.m_wstrb <= (cmd == CMD_WRITE) ? 4'hF : 4'h0;
          end
        end
        ST_BUS: if (rsp_go) begin
          bus.m_valid <= 1'b0;
          state       <= ST_RESP;
        end else begin
          tmo <= tmo + 32'd1;
        end
        ST_RESP: if (rsp_done) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_bm_resp_tx u_resp (
    .clk      (clk),
    .reset    (reset),
    .start    (rsp_go),
    .word     (rsp_word),
    .len      (rsp_len),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .done     (rsp_done)
  );
endmodule
